// File: rtl/ctrl_pkg.sv
// Shared constants for the accumulator controller family.
// Opcode map, ALU select codes, FSM encoding and width defaults.
package ctrl_pkg;

  localparam int DEF_OPC_W   = 4;
  localparam int DEF_SHAMT_W = 3;
  localparam int DEF_ALU_W   = 3;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_ADD_A = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SUB_A = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_AND_A = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_OR_A  = 4'b0111;
  localparam logic [3:0] OP_SHR   = 4'b1000;
  localparam logic [3:0] OP_SHL   = 4'b1001;
  localparam logic [3:0] OP_LDA   = 4'b1010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SHR1 = 3'b100;
  localparam logic [2:0] ALU_SHL1 = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_SHIFT,
    S_DONE
  } state_t;

  function automatic logic [2:0] alu_sel(
    input logic [3:0] opc
  );
    logic [2:0] r;
    r = ALU_ADD;
    unique case (1'b1)
      (opc == OP_SUB || opc == OP_SUB_A): r = ALU_SUB;
      (opc == OP_AND || opc == OP_AND_A): r = ALU_AND;
      (opc == OP_OR  || opc == OP_OR_A):  r = ALU_OR;
      (opc == OP_SHR):                    r = ALU_SHR1;
      (opc == OP_SHL):                    r = ALU_SHL1;
      default:                            r = ALU_ADD;
    endcase
    return r;
  endfunction

  function automatic logic is_illegal(
    input logic [3:0] opc
  );
    return opc > OP_LDA;
  endfunction

endpackage

// File: rtl/cmd_pending_buf.sv
// One-entry holding register for a command strobed while busy.
// A strobe arriving with the slot full is discarded and flagged.
module cmd_pending_buf
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = DEF_OPC_W,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               capture,
  input  logic               consume,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               pend_valid,
  output logic [OPC_W-1:0]   pend_opcode,
  output logic [SHAMT_W-1:0] pend_shamt,
  output logic               drop
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid  <= 1'b0;
      pend_opcode <= '0;
      pend_shamt  <= '0;
      drop        <= 1'b0;
    end else begin
      drop <= capture && pend_valid;
      if (consume) begin
        pend_valid <= 1'b0;
      end else if (capture && !pend_valid) begin
        pend_valid  <= 1'b1;
        pend_opcode <= opcode;
        pend_shamt  <= shamt;
      end
    end
  end

endmodule

// File: rtl/exec_controller.sv
// Multi-cycle accumulator controller: decode, execute, shift.
// All outputs are registered and describe the state being entered.
module exec_controller
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = DEF_OPC_W,
  parameter int SHAMT_W = DEF_SHAMT_W,
  parameter int ALU_W   = DEF_ALU_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [ALU_W-1:0]   alu_signals,
  output logic               b_sel,
  output logic               acc_load,
  output logic               acc_mux,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic               drop
);

  state_t             state;
  logic [OPC_W-1:0]   opc_q;
  logic [SHAMT_W-1:0] sh_q;
  logic [SHAMT_W-1:0] cnt;

  logic               pend_valid;
  logic [OPC_W-1:0]   pend_opcode;
  logic [SHAMT_W-1:0] pend_shamt;
  logic               capture;
  logic               consume;
  logic               is_shift;
  logic               is_exec;

  // In DONE with an empty slot a new strobe goes straight to DECODE.
  assign capture = op && (state != S_IDLE) &&
                   !((state == S_DONE) && !pend_valid);
  assign consume = (state == S_DONE) && pend_valid;

  assign is_shift = (opc_q == OP_SHR) || (opc_q == OP_SHL);
  assign is_exec  = !is_illegal(opc_q) && !is_shift;

  cmd_pending_buf #(
    .OPC_W   (OPC_W),
    .SHAMT_W (SHAMT_W)
  ) u_pend (
    .clk         (clk),
    .reset       (reset),
    .capture     (capture),
    .consume     (consume),
    .opcode      (opcode),
    .shamt       (shamt),
    .pend_valid  (pend_valid),
    .pend_opcode (pend_opcode),
    .pend_shamt  (pend_shamt),
    .drop        (drop)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      opc_q       <= '0;
      sh_q        <= '0;
      cnt         <= '0;
      alu_signals <= '0;
      b_sel       <= 1'b0;
      acc_load    <= 1'b0;
      acc_mux     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      alu_signals <= '0;
      b_sel       <= 1'b0;
      acc_load    <= 1'b0;
      acc_mux     <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (op) begin
            opc_q <= opcode;
            sh_q  <= shamt;
            state <= S_DECODE;
            busy  <= 1'b1;
          end
        end
        S_DECODE: begin
          if (is_exec) begin
            state       <= S_EXEC;
            acc_load    <= 1'b1;
            alu_signals <= ALU_W'(alu_sel(opc_q));
            b_sel       <= (opc_q < OP_SHR) ? opc_q[0] : 1'b0;
            acc_mux     <= (opc_q != OP_LDA);
          end else if (is_shift && (sh_q != '0)) begin
            state       <= S_SHIFT;
            cnt         <= sh_q;
            acc_load    <= 1'b1;
            acc_mux     <= 1'b1;
            alu_signals <= ALU_W'(alu_sel(opc_q));
          end else begin
            state   <= S_DONE;
            done    <= 1'b1;
            illegal <= is_illegal(opc_q);
          end
        end
        S_EXEC: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_SHIFT: begin
          if (cnt == SHAMT_W'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            cnt         <= cnt - SHAMT_W'(1);
            acc_load    <= 1'b1;
            acc_mux     <= 1'b1;
            alu_signals <= ALU_W'(alu_sel(opc_q));
          end
        end
        S_DONE: begin
          if (pend_valid) begin
            opc_q <= pend_opcode;
            sh_q  <= pend_shamt;
            state <= S_DECODE;
          end else if (op) begin
            opc_q <= opcode;
            sh_q  <= shamt;
            state <= S_DECODE;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
